// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-cache request/response, redirect input
// and the IF/ID register outputs toward decode.
interface fetch_unit_if #(
  parameter int ADDRESS_SIZE     = 64,
  parameter int INSTRUCTION_SIZE = 32
);
  logic                        instruction_read;
  logic [ADDRESS_SIZE-1:0]     instruction_address;
  logic [INSTRUCTION_SIZE-1:0] instruction_response;
  logic                        busy;
  logic                        redirect_valid;
  logic [ADDRESS_SIZE-1:0]     redirect_pc;
  logic                        if_valid;
  logic                        if_ready;
  logic [ADDRESS_SIZE-1:0]     if_pc;
  logic [INSTRUCTION_SIZE-1:0] if_instruction;

  modport master (
    output instruction_read, instruction_address, if_valid, if_pc, if_instruction,
    input  instruction_response, busy, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  instruction_read, instruction_address, if_valid, if_pc, if_instruction,
    output instruction_response, busy, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch: requests one word at a time from the cache,
// holds it in the IF/ID register until decode accepts, and follows redirects.
module fetch_unit #(
  parameter int ADDRESS_SIZE     = 64,
  parameter int INSTRUCTION_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRESS_SIZE-1:0] entry,
  fetch_unit_if.master            bus,
  output logic [31:0]             fetch_count
);

  localparam logic [2:0] ST_BOOT  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [ADDRESS_SIZE-1:0] WORD_MASK = ~ADDRESS_SIZE'(3);
  localparam logic [ADDRESS_SIZE-1:0] WORD_STEP = ADDRESS_SIZE'(4);

  logic [2:0]                  state;
  logic [ADDRESS_SIZE-1:0]     pc;
  logic                        read_q;
  logic [ADDRESS_SIZE-1:0]     address_q;
  logic                        valid_q;
  logic [ADDRESS_SIZE-1:0]     if_pc_q;
  logic [INSTRUCTION_SIZE-1:0] instr_q;
  logic [31:0]                 count_q;

  logic [ADDRESS_SIZE-1:0]     entry_target;
  logic [ADDRESS_SIZE-1:0]     redirect_target;

  assign entry_target    = entry & WORD_MASK;
  assign redirect_target = bus.redirect_pc & WORD_MASK;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_BOOT;
      pc        <= '0;
      read_q    <= 1'b0;
      address_q <= '0;
      valid_q   <= 1'b0;
      if_pc_q   <= '0;
      instr_q   <= '0;
      count_q   <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          pc    <= bus.redirect_valid ? redirect_target : entry_target;
          state <= ST_REQ;
        end
        // REQ is entered with the read line low; its first cycle raises the
        // registered read/address, later cycles wait for the cache to go busy.
        ST_REQ: begin
          if (bus.redirect_valid) begin
            pc     <= redirect_target;
            read_q <= 1'b0;
          end else if (!read_q) begin
            read_q    <= 1'b1;
            address_q <= pc;
          end else if (bus.busy) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.redirect_valid) begin
            pc     <= redirect_target;
            read_q <= 1'b0;
            state  <= ST_DRAIN;
          end else if (!bus.busy) begin
            instr_q <= bus.instruction_response;
            if_pc_q <= pc;
            valid_q <= 1'b1;
            read_q  <= 1'b0;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.redirect_valid) begin
            pc      <= redirect_target;
            valid_q <= 1'b0;
            state   <= ST_REQ;
          end else if (valid_q && bus.if_ready) begin
            pc      <= pc + WORD_STEP;
            valid_q <= 1'b0;
            count_q <= count_q + 32'd1;
            state   <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (bus.redirect_valid) begin
            pc <= redirect_target;
          end else if (!bus.busy) begin
            state <= ST_REQ;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  assign bus.instruction_read    = read_q;
  assign bus.instruction_address = address_q;
  assign bus.if_valid            = valid_q;
  assign bus.if_pc               = if_pc_q;
  assign bus.if_instruction      = instr_q;
  assign fetch_count             = count_q;

endmodule
